// File: rtl/pong_pkg.sv
// Shared definitions for the pong status link: packet layout, event codes,
// snapshot record and the serializer state encoding.
package pong_pkg;

  localparam logic [7:0] PKT_HDR   = 8'hA5;
  localparam int         PKT_BYTES = 5;

  localparam logic [2:0] EVT_IDLE  = 3'd0;
  localparam logic [2:0] EVT_SERVE = 3'd1;
  localparam logic [2:0] EVT_HIT   = 3'd2;
  localparam logic [2:0] EVT_PT_R  = 3'd3;
  localparam logic [2:0] EVT_PT_L  = 3'd4;

  typedef struct packed {
    logic [3:0] score_r;
    logic [3:0] score_l;
    logic [7:0] ball;
    logic [2:0] evt;
  } pkt_snap_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } tx_state_e;

  function automatic logic [7:0] pkt_checksum(input pkt_snap_t s);
    return {s.score_r, s.score_l} ^ s.ball ^ {5'b0, s.evt};
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer, LSB first, idle high. A new byte offered during the
// last cycle of a stop bit starts its start bit with no idle gap.
module uart_byte_tx
  import pong_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       byte_valid_i,
  input  logic [7:0] byte_data_i,
  output logic       byte_ready_o,
  output logic       byte_done_o,
  output logic       txd_o
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);

  tx_state_e   state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        txd_q, txd_d;
  logic        baud_last;

  assign baud_last    = (baud_q == BAUD_MAX);
  assign byte_done_o  = (state_q == ST_STOP) && baud_last;
  assign byte_ready_o = (state_q == ST_IDLE) || byte_done_o;
  assign txd_o        = txd_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_last ? 16'd0 : baud_q + 16'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (byte_valid_i) begin
          state_d = ST_START;
          shift_d = byte_data_i;
          txd_d   = 1'b0;
        end
      end
      ST_START: begin
        if (baud_last) begin
          state_d = ST_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
        end
      end
      ST_DATA: begin
        if (baud_last) begin
          if (bit_q == 3'd7) begin
            state_d = ST_STOP;
            txd_d   = 1'b1;
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = shift_q >> 1;
            txd_d   = shift_q[1];
          end
        end
      end
      ST_STOP: begin
        if (baud_last) begin
          if (byte_valid_i) begin
            state_d = ST_START;
            shift_d = byte_data_i;
            txd_d   = 1'b0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/pong_score_tx.sv
// Packet sequencer for the pong status link: snapshot capture with one-deep
// pending buffer, checksum, and byte hand-off to the serializer.
module pong_score_tx
  import pong_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_valid,
  output logic       send_ready,
  input  logic [3:0] score_r,
  input  logic [3:0] score_l,
  input  logic [7:0] ball,
  input  logic [2:0] evt,
  output logic       txd,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

  pkt_snap_t  snap_in, active_q, active_d, pend_q, pend_d;
  logic [7:0] chk_q, chk_d;
  logic [2:0] idx_q, idx_d;
  logic       pend_full_q, pend_full_d;
  logic       load_q, load_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;

  logic       accept, pkt_end;
  logic       byte_valid, byte_ready, byte_done;
  logic [2:0] byte_sel;
  logic [7:0] byte_data;

  assign snap_in = {score_r, score_l, ball, evt};
  assign accept  = send_valid && ready_q;
  assign pkt_end = busy_q && byte_done && (idx_q == LAST_IDX);

  assign send_ready = ready_q;
  assign busy       = busy_q;
  assign done       = done_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q    <= '0;
      pend_q      <= '0;
      chk_q       <= '0;
      idx_q       <= '0;
      pend_full_q <= 1'b0;
      load_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      active_q    <= active_d;
      pend_q      <= pend_d;
      chk_q       <= chk_d;
      idx_q       <= idx_d;
      pend_full_q <= pend_full_d;
      load_q      <= load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    active_d    = active_q;
    pend_d      = pend_q;
    chk_d       = chk_q;
    idx_d       = idx_q;
    pend_full_d = pend_full_q;
    load_d      = load_q;
    busy_d      = busy_q;
    done_d      = pkt_end;
    byte_valid  = 1'b0;
    byte_sel    = '0;

    // A fresh snapshot from idle launches its header one cycle after capture.
    if (load_q) begin
      byte_valid = 1'b1;
      if (byte_ready) begin
        load_d = 1'b0;
        busy_d = 1'b1;
        idx_d  = '0;
      end
    end else if (busy_q && byte_done) begin
      if (idx_q != LAST_IDX) begin
        byte_valid = 1'b1;
        byte_sel   = idx_q + 3'd1;
        idx_d      = idx_q + 3'd1;
      end else begin
        // Header is constant, so a follow-on packet can start on this edge.
        idx_d = '0;
        if (pend_full_q) begin
          byte_valid  = 1'b1;
          active_d    = pend_q;
          chk_d       = pkt_checksum(pend_q);
          pend_full_d = 1'b0;
        end else if (accept) begin
          byte_valid = 1'b1;
          active_d   = snap_in;
          chk_d      = pkt_checksum(snap_in);
        end else begin
          busy_d = 1'b0;
        end
      end
    end

    if (accept && !pkt_end) begin
      if (!busy_q && !load_q) begin
        active_d = snap_in;
        chk_d    = pkt_checksum(snap_in);
        load_d   = 1'b1;
      end else begin
        pend_d      = snap_in;
        pend_full_d = 1'b1;
      end
    end

    ready_d = !pend_full_d;
  end

  always_comb begin
    unique case (byte_sel)
      3'd0:    byte_data = PKT_HDR;
      3'd1:    byte_data = {active_q.score_r, active_q.score_l};
      3'd2:    byte_data = active_q.ball;
      3'd3:    byte_data = {5'b0, active_q.evt};
      default: byte_data = chk_q;
    endcase
  end

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk         (clk),
    .rst         (rst),
    .byte_valid_i(byte_valid),
    .byte_data_i (byte_data),
    .byte_ready_o(byte_ready),
    .byte_done_o (byte_done),
    .txd_o       (txd)
  );

endmodule

// File: tb/tb_pong_score_tx.sv
// Directed bench for pong_score_tx at 4 clocks per bit: decodes the serial
// line and checks bytes, framing, handshake and done/busy timing.
module tb_pong_score_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       send_valid = 1'b0;
  logic [3:0] score_r = '0;
  logic [3:0] score_l = '0;
  logic [7:0] ball = '0;
  logic [2:0] evt = '0;
  logic       send_ready, txd, busy, done;

  pong_score_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .send_valid(send_valid),
    .send_ready(send_ready),
    .score_r   (score_r),
    .score_l   (score_l),
    .ball      (ball),
    .evt       (evt),
    .txd       (txd),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  int errors = 0;
  int checks = 0;
  int accept_cyc, rx_start_cyc, a_start, done_base, bad;
  logic [7:0] rx_bytes [5];
  logic [7:0] a_bytes  [5];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pkt(input string tag, input logic [7:0] got [5],
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                         input logic [7:0] e3, input logic [7:0] e4);
    logic [7:0] e [5];
    e = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < 5; i++) chk($sformatf("%s_b%0d", tag, i), {24'd0, got[i]}, {24'd0, e[i]});
  endtask

  // Waits (bounded) for a start bit, then samples all 50 bit periods.
  task automatic rx_packet(input string tag);
    int n = 0;
    int bp;
    logic ferr = 1'b0;
    @(negedge clk);
    while (txd !== 1'b0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start_seen"}, {31'd0, txd}, 32'd0);
    if (txd !== 1'b0) return;
    rx_start_cyc = cyc;
    for (int p = 0; p < 50; p++) begin
      bp = p % 10;
      for (int c = 0; c < CPB; c++) begin
        if (p != 0 || c != 0) @(negedge clk);
        if (bp == 0) begin
          if (txd !== 1'b0) ferr = 1'b1;
        end else if (bp == 9) begin
          if (txd !== 1'b1) ferr = 1'b1;
        end else if (c == 0) begin
          rx_bytes[p/10][bp-1] = txd;
        end else if (txd !== rx_bytes[p/10][bp-1]) begin
          ferr = 1'b1;
        end
      end
    end
    chk({tag, "_framing"}, {31'd0, ferr}, 32'd0);
  endtask

  task automatic do_send(input logic [3:0] r, input logic [3:0] l,
                         input logic [7:0] b, input logic [2:0] e);
    int n = 0;
    while (send_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready_wait", {31'd0, send_ready}, 32'd1);
    score_r = r; score_l = l; ball = b; evt = e;
    send_valid = 1'b1;
    @(negedge clk);
    send_valid = 1'b0;
    accept_cyc = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_ready", {31'd0, send_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rst = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (txd !== 1'b1 || send_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
    end
    chk("idle_100", bad, 0);

    // Single packet, with an input change right after acceptance
    done_base = done_cnt;
    fork
      rx_packet("single");
      begin
        do_send(4'd3, 4'd5, 8'h10, 3'd2);
        chk("single_busy_at_N", {31'd0, busy}, 32'd0);
        chk("single_txd_at_N", {31'd0, txd}, 32'd1);
        score_r = 4'd9;
        @(negedge clk);
        chk("single_busy_N1", {31'd0, busy}, 32'd1);
        chk("single_txd_N1", {31'd0, txd}, 32'd0);
      end
    join
    chk_pkt("single", rx_bytes, 8'hA5, 8'h35, 8'h10, 8'h02, 8'h27);
    chk("single_start_lat", rx_start_cyc - accept_cyc, 1);
    @(negedge clk);
    chk("single_done", {31'd0, done}, 32'd1);
    chk("single_done_lat", cyc - accept_cyc, 201);
    chk("single_busy_end", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("single_done_once", {31'd0, done}, 32'd0);
    chk("single_done_cnt", done_cnt - done_base, 1);

    // Pending buffer, with a third request held off
    done_base = done_cnt;
    fork
      begin
        rx_packet("pendA");
        a_bytes = rx_bytes;
        a_start = rx_start_cyc;
        rx_packet("pendB");
      end
      begin
        do_send(4'd1, 4'd0, 8'h01, 3'd1);
        repeat (20) @(negedge clk);
        chk("pend_ready_busy", {31'd0, send_ready}, 32'd1);
        do_send(4'd0, 4'd1, 8'h80, 3'd4);
        chk("pend_ready_drop", {31'd0, send_ready}, 32'd0);
        score_r = 4'd7; score_l = 4'd7; ball = 8'hFF; evt = 3'd3;
        send_valid = 1'b1;
        bad = 0;
        repeat (20) begin
          @(negedge clk);
          if (send_ready !== 1'b0) bad++;
        end
        send_valid = 1'b0;
        chk("pend_holdoff", bad, 0);
        bad = 0;
        for (int n = 0; n < 300 && done !== 1'b1; n++) begin
          if (send_ready !== 1'b0) bad++;
          @(negedge clk);
        end
        chk("pend_ready_low_til_end", bad, 0);
        chk("pend_A_done", {31'd0, done}, 32'd1);
        chk("pend_ready_rise", {31'd0, send_ready}, 32'd1);
        chk("pend_busy_cont", {31'd0, busy}, 32'd1);
        chk("pend_txd_startB", {31'd0, txd}, 32'd0);
      end
    join
    chk_pkt("pendA", a_bytes, 8'hA5, 8'h10, 8'h01, 8'h01, 8'h10);
    chk_pkt("pendB", rx_bytes, 8'hA5, 8'h01, 8'h80, 8'h04, 8'h85);
    chk("pend_gap", rx_start_cyc - a_start, 200);
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1) bad++;
    end
    chk("pend_no_third", bad, 0);
    chk("pend_done_cnt", done_cnt - done_base, 2);

    // Back-to-back accept on the done edge
    fork
      begin
        rx_packet("b2bA");
        a_bytes = rx_bytes;
        a_start = rx_start_cyc;
        rx_packet("b2bB");
      end
      begin
        do_send(4'd2, 4'd2, 8'h3C, 3'd1);
        repeat (200) @(negedge clk);
        score_r = 4'd4; score_l = 4'd6; ball = 8'hC3; evt = 3'd3;
        send_valid = 1'b1;
        @(negedge clk);
        send_valid = 1'b0;
        chk("b2b_done", {31'd0, done}, 32'd1);
        chk("b2b_done_lat", cyc - accept_cyc, 201);
        chk("b2b_busy", {31'd0, busy}, 32'd1);
        chk("b2b_txd", {31'd0, txd}, 32'd0);
      end
    join
    chk_pkt("b2bA", a_bytes, 8'hA5, 8'h22, 8'h3C, 8'h01, 8'h1F);
    chk_pkt("b2bB", rx_bytes, 8'hA5, 8'h46, 8'hC3, 8'h03, 8'h86);
    chk("b2b_gap", rx_start_cyc - a_start, 200);
    repeat (10) @(negedge clk);

    // Reset during B2, then a clean packet with a reserved event code
    do_send(4'd5, 4'd9, 8'hAA, 3'd3);
    repeat (90) @(negedge clk);
    chk("rstmid_busy_before", {31'd0, busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("rstmid_txd", {31'd0, txd}, 32'd1);
    chk("rstmid_ready", {31'd0, send_ready}, 32'd1);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (txd !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("rstmid_no_resume", bad, 0);
    fork
      rx_packet("post");
      do_send(4'd9, 4'd4, 8'h5A, 3'd7);
    join
    chk_pkt("post", rx_bytes, 8'hA5, 8'h94, 8'h5A, 8'h07, 8'hC9);
    chk("post_start_lat", rx_start_cyc - accept_cyc, 1);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
